jtag_scan_controller: RTL and testbench
=======================================

Name: jtag_scan_controller

Overview:
- Synthesizable JTAG master scan engine, directly upstream of the TAP under test.
- Consumes one scan request per handshake: test vector, vector width, instruction width and instruction opcode, using the package's width/opcode/TAP-state encodings.
- Generates TCK/TMS/TDI, walks the TAP through an IR scan then a DR scan, captures TDO during the DR shift, and returns the captured word with a done pulse.
- Tracks the TAP state internally and exports it for monitors and scoreboards.

Parameters:
- MAX_VECTOR_WIDTH, 32, width of the testVector and capturedData buses.
- MAX_INSTR_WIDTH, 5, width of the instrOpcode bus.

Ports:
- clk  input  1  system clock; TCK is derived as clk/2.
- reset  input  1  asynchronous, active-low reset.
- startValid  input  1  scan request valid.
- startReady  output  1  controller idle and able to accept a request.
- testVector  input  MAX_VECTOR_WIDTH  DR data, shifted LSB first.
- vectorWidth  input  6  DR length; legal values 8/16/24/32.
- instrWidth  input  3  IR length; legal values 3/4/5.
- instrOpcode  input  MAX_INSTR_WIDTH  IR data, shifted LSB first (00000 bypass, 00001 user-defined, 00010 boundary scan).
- tck  output  1  JTAG test clock.
- tms  output  1  test mode select.
- tdi  output  1  test data in.
- tdo  input  1  test data out from the TAP.
- capturedData  output  MAX_VECTOR_WIDTH  TDO bits from the DR shift, right-justified.
- done  output  1  one-clk pulse when a scan completes.
- error  output  1  one-clk pulse when a request is rejected.
- tapState  output  4  modelled TAP state, encoded 0..15 in JtagTapStates order (reset=0, idle=1, selectDr=2, selectIr=3, captureIr=4 ... updateDr=15).

Behaviour:
- Reset values (asynchronous, while reset is low): tck=0, tms=1, tdi=0, startReady=0, done=0, error=0, capturedData=0, tapState=0.
- TCK timing: each TCK period is 2 clk cycles, a low phase followed by a high phase.
  - tms/tdi change only at the clk edge that starts a low phase.
  - tapState updates at the edge that raises tck.
  - tdo is sampled at the edge that ends the high phase.
- After reset release, the controller drives one TCK with tms=0 (reset->idle), then asserts startReady.
- Handshake: a request is accepted on the clk edge where startValid&&startReady are both high.
  - startReady deasserts the next cycle and stays low until the controller is back in idle.
  - Inputs are registered at accept, so they may change afterwards.
- Illegal request (vectorWidth outside {8,16,24,32} or instrWidth outside 3..5): still accepted, error pulses 1 cycle later, no TCK activity, done is not asserted, startReady returns the following cycle.
- Scan sequence, TMS value per TCK rising edge:
  - IR scan: 1,1,0,0, then n IR bits with TMS=0 except the last bit (TMS=1), then 1,0.
  - DR scan: 1,0,0, then m DR bits with TMS=0 except the last bit (TMS=1), then 1,0.
  - Total length is n+m+11 TCK periods.
- Controller FSM: IDLE, IR_PRE, IR_SHIFT, IR_POST, DR_PRE, DR_SHIFT, DR_POST, FINISH. A bit counter counts down from width-1, and the last bit is flagged when the counter reaches 0.
- TDI: bit k of the opcode/vector is driven for the k-th shift edge. tdi=0 outside the shift states.
- TDO capture:
  - Bit k of capturedData is the tdo sample after the k-th DR shift edge.
  - Bits >= m are 0.
  - IR-phase tdo is ignored.
  - capturedData is cleared at accept and holds its value after done.
- done pulses 1 cycle after tapState returns to idle; startReady rises in the same cycle as done.
- TAP model: the full 16-state IEEE 1149.1 transition table, driven by tms at each TCK rising edge, independent of the controller FSM.
- Reset asserted mid-scan: the scan aborts immediately, all outputs take their reset values, no done is produced, and the post-reset idle entry repeats.

Optional Feature:
- Macro: JTAG_RESET_ON_START_EN.
- Defined: every accepted legal request is prefixed with 5 TCK at tms=1 (TAP forced to reset), then 1 TCK at tms=0 (idle), before the IR scan. The scan grows by 6 TCK (n+m+17 total), and tapState passes through 0 during the prefix.
- Undefined: no prefix; each scan starts directly from idle.

Test Plan:
- Reset release -> 1 TCK with tms=0, tapState 0->1, startReady=1 at clk cycle 3.
- opcode=00010, n=5, vector=0xA5, m=8, tdo looped to tdi delayed by one TCK -> 24 TCK (48 clk), tdi shows IR bits 0,1,0,0,0, capturedData=0x000000A5 less its loopback shift (the bench checks its expected value against the modelled delay), done pulse, tapState visits 6 and 11.
- m=32, n=3, tdo tied 1 -> 46 TCK, capturedData=0xFFFFFFFF.
- vectorWidth=12 -> error pulse 1 cycle after accept, tck stays 0, no done, startReady back high the following cycle.
- Reset asserted while tapState=11 (shiftDr) -> tck=0, tms=1, tapState=0 immediately; after release, idle is re-entered and no done is produced.
- JTAG_RESET_ON_START_EN defined, n=5, m=8 -> 30 TCK with the first 5 tms=1, and tapState=0 before IR entry.

Source files
------------

// File: rtl/jtag_scan_controller_if.sv
// Request/response channel of the JTAG scan controller: one scan per startValid/startReady
// handshake, answered by a done (scan finished) or error (request rejected) pulse.
interface jtag_scan_controller_if #(
  parameter int MAX_VECTOR_WIDTH = 32,
  parameter int MAX_INSTR_WIDTH  = 5
);
  logic                        startValid;
  logic                        startReady;
  logic [MAX_VECTOR_WIDTH-1:0] testVector;
  logic [5:0]                  vectorWidth;
  logic [2:0]                  instrWidth;
  logic [MAX_INSTR_WIDTH-1:0]  instrOpcode;
  logic [MAX_VECTOR_WIDTH-1:0] capturedData;
  logic                        done;
  logic                        error;

  modport master (output startValid, testVector, vectorWidth, instrWidth, instrOpcode,
                  input  startReady, capturedData, done, error);
  modport slave  (input  startValid, testVector, vectorWidth, instrWidth, instrOpcode,
                  output startReady, capturedData, done, error);
endinterface

// File: rtl/jtag_scan_controller.sv
// JTAG master scan engine: TCK = clk/2, IR scan then DR scan, TDO captured during DR shift.
// Optional JTAG_RESET_ON_START_EN: prefix each legal scan with 5x TMS=1 plus 1x TMS=0.
module jtag_scan_controller #(
  parameter int MAX_VECTOR_WIDTH = 32,
  parameter int MAX_INSTR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  jtag_scan_controller_if.slave bus,
  output logic                  tck,
  output logic                  tms,
  output logic                  tdi,
  input  logic                  tdo,
  output logic [3:0]            tapState
);
  localparam int VIDX_W = $clog2(MAX_VECTOR_WIDTH);
  localparam int IIDX_W = $clog2(MAX_INSTR_WIDTH);

  typedef enum logic [3:0] {
    TAP_RESET    = 4'd0,  TAP_IDLE     = 4'd1,  TAP_SEL_DR    = 4'd2,  TAP_SEL_IR    = 4'd3,
    TAP_CAP_IR   = 4'd4,  TAP_SHIFT_IR = 4'd5,  TAP_EXIT1_IR  = 4'd6,  TAP_PAUSE_IR  = 4'd7,
    TAP_EXIT2_IR = 4'd8,  TAP_UPD_IR   = 4'd9,  TAP_CAP_DR    = 4'd10, TAP_SHIFT_DR  = 4'd11,
    TAP_EXIT1_DR = 4'd12, TAP_PAUSE_DR = 4'd13, TAP_EXIT2_DR  = 4'd14, TAP_UPD_DR    = 4'd15
  } tap_state_t;

  typedef enum logic [3:0] {
    S_WAKE, S_BOOT, S_IDLE, S_REJECT, S_RST_PRE, S_IR_PRE,
    S_IR_SHIFT, S_IR_POST, S_DR_PRE, S_DR_SHIFT, S_DR_POST, S_FINISH
  } ctrl_state_t;

`ifdef JTAG_RESET_ON_START_EN
  localparam ctrl_state_t FIRST_STATE = S_RST_PRE;
  localparam logic [5:0]  FIRST_CNT   = 6'd5;
`else
  localparam ctrl_state_t FIRST_STATE = S_IR_PRE;
  localparam logic [5:0]  FIRST_CNT   = 6'd3;
`endif

  function automatic tap_state_t tap_step(tap_state_t s, logic m);
    case (s)
      TAP_RESET:    return m ? TAP_RESET    : TAP_IDLE;
      TAP_IDLE:     return m ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_DR:   return m ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_SEL_IR:   return m ? TAP_RESET    : TAP_CAP_IR;
      TAP_CAP_IR:   return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: return m ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return m ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: return m ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   return m ? TAP_SEL_DR   : TAP_IDLE;
      TAP_CAP_DR:   return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: return m ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return m ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: return m ? TAP_UPD_DR   : TAP_SHIFT_DR;
      default:      return m ? TAP_SEL_DR   : TAP_IDLE;
    endcase
  endfunction

  // TMS for the TCK slot identified by controller state and down-counter value.
  function automatic logic slot_tms(ctrl_state_t st, logic [5:0] c);
    case (st)
      S_RST_PRE:              return c != 6'd0;
      S_IR_PRE:               return c >= 6'd2;
      S_IR_SHIFT, S_DR_SHIFT: return c == 6'd0;
      S_IR_POST:              return c == 6'd1;
      S_DR_PRE:               return c == 6'd2;
      S_DR_POST:              return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  ctrl_state_t                 state_reg, state_next;
  tap_state_t                  tap_reg, tap_next;
  logic [5:0]                  cnt_reg, cnt_next;
  logic                        tck_reg, tck_next, tms_reg, tms_next, tdi_reg, tdi_next;
  logic                        ready_reg, ready_next, done_reg, done_next, error_reg, error_next;
  logic [MAX_VECTOR_WIDTH-1:0] cap_reg, cap_next, vec_reg, vec_next;
  logic [MAX_INSTR_WIDTH-1:0]  op_reg, op_next;
  logic [5:0]                  vw_reg, vw_next;
  logic [2:0]                  iw_reg, iw_next;
  logic [VIDX_W-1:0]           dr_idx, dr_idx_n;
  logic [IIDX_W-1:0]           ir_idx_n;
  logic                        req_legal;

  always_comb begin
    req_legal = (bus.vectorWidth == 6'd8 || bus.vectorWidth == 6'd16 ||
                 bus.vectorWidth == 6'd24 || bus.vectorWidth == 6'd32) &&
                (32'(bus.vectorWidth) <= MAX_VECTOR_WIDTH) &&
                (bus.instrWidth >= 3'd3) && (bus.instrWidth <= 3'd5) &&
                (32'(bus.instrWidth) <= MAX_INSTR_WIDTH);
  end

  always_comb begin
    state_next = state_reg;
    tap_next   = tap_reg;
    cnt_next   = cnt_reg;
    tck_next   = tck_reg;
    tms_next   = tms_reg;
    tdi_next   = tdi_reg;
    ready_next = ready_reg;
    done_next  = 1'b0;
    error_next = 1'b0;
    cap_next   = cap_reg;
    vec_next   = vec_reg;
    op_next    = op_reg;
    vw_next    = vw_reg;
    iw_next    = iw_reg;
    dr_idx     = VIDX_W'(vw_reg - 6'd1 - cnt_reg);
    dr_idx_n   = '0;
    ir_idx_n   = '0;
    case (state_reg)
      S_WAKE: begin
        state_next = S_BOOT;
        tms_next   = 1'b0;
      end
      S_IDLE: begin
        ready_next = 1'b1;
        if (bus.startValid && ready_reg) begin
          ready_next = 1'b0;
          cap_next   = '0;
          vec_next   = bus.testVector;
          op_next    = bus.instrOpcode;
          vw_next    = bus.vectorWidth;
          iw_next    = bus.instrWidth;
          if (req_legal) begin
            state_next = FIRST_STATE;
            cnt_next   = FIRST_CNT;
            tms_next   = slot_tms(FIRST_STATE, FIRST_CNT);
          end else begin
            state_next = S_REJECT;
          end
        end
      end
      S_REJECT: begin
        error_next = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        if (!tck_reg) begin
          tck_next = 1'b1;
          tap_next = tap_step(tap_reg, tms_reg);
        end else begin
          // End of the high phase: sample TDO, then set up TMS/TDI of the next slot.
          tck_next = 1'b0;
          if (state_reg == S_DR_SHIFT) cap_next[dr_idx] = tdo;
          if (cnt_reg != 6'd0) begin
            cnt_next = cnt_reg - 6'd1;
          end else begin
            case (state_reg)
              S_RST_PRE:  begin state_next = S_IR_PRE;   cnt_next = 6'd3; end
              S_IR_PRE:   begin state_next = S_IR_SHIFT; cnt_next = {3'b000, iw_reg} - 6'd1; end
              S_IR_SHIFT: begin state_next = S_IR_POST;  cnt_next = 6'd1; end
              S_IR_POST:  begin state_next = S_DR_PRE;   cnt_next = 6'd2; end
              S_DR_PRE:   begin state_next = S_DR_SHIFT; cnt_next = vw_reg - 6'd1; end
              S_DR_SHIFT: begin state_next = S_DR_POST;  cnt_next = 6'd0; end
              S_DR_POST:  begin state_next = S_FINISH;   cnt_next = 6'd0; end
              S_FINISH: begin
                state_next = S_IDLE;
                done_next  = 1'b1;
                ready_next = 1'b1;
              end
              default: begin
                state_next = S_IDLE;
                ready_next = 1'b1;
              end
            endcase
          end
          ir_idx_n = IIDX_W'({3'b000, iw_reg} - 6'd1 - cnt_next);
          dr_idx_n = VIDX_W'(vw_reg - 6'd1 - cnt_next);
          tms_next = slot_tms(state_next, cnt_next);
          tdi_next = 1'b0;
          if (state_next == S_IR_SHIFT)      tdi_next = op_reg[ir_idx_n];
          else if (state_next == S_DR_SHIFT) tdi_next = vec_reg[dr_idx_n];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_WAKE;
      tap_reg   <= TAP_RESET;
      cnt_reg   <= '0;
      tck_reg   <= 1'b0;
      tms_reg   <= 1'b1;
      tdi_reg   <= 1'b0;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      cap_reg   <= '0;
      vec_reg   <= '0;
      op_reg    <= '0;
      vw_reg    <= '0;
      iw_reg    <= '0;
    end else begin
      state_reg <= state_next;
      tap_reg   <= tap_next;
      cnt_reg   <= cnt_next;
      tck_reg   <= tck_next;
      tms_reg   <= tms_next;
      tdi_reg   <= tdi_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      cap_reg   <= cap_next;
      vec_reg   <= vec_next;
      op_reg    <= op_next;
      vw_reg    <= vw_next;
      iw_reg    <= iw_next;
    end
  end

  assign tck              = tck_reg;
  assign tms              = tms_reg;
  assign tdi              = tdi_reg;
  assign tapState         = tap_reg;
  assign bus.startReady   = ready_reg;
  assign bus.capturedData = cap_reg;
  assign bus.done         = done_reg;
  assign bus.error        = error_reg;
endmodule

// File: tb/tb_jtag_scan_controller.sv
// Scoreboard bench for jtag_scan_controller: expected scan results queued at request time,
// popped and compared when done/error appears.
module tb_jtag_scan_controller;
  localparam int VW = 32;
  localparam int IW = 5;
`ifdef JTAG_RESET_ON_START_EN
  localparam int PRE = 6;
`else
  localparam int PRE = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tck, tms, tdi;
  logic       tdo = 1'b0;
  logic [3:0] tapState;

  jtag_scan_controller_if #(.MAX_VECTOR_WIDTH(VW), .MAX_INSTR_WIDTH(IW)) bus ();

  jtag_scan_controller #(.MAX_VECTOR_WIDTH(VW), .MAX_INSTR_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tapState(tapState)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] cap;
    int          tcks;
    logic [63:0] tms_seq;
  } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  // TAP stand-in: either a one-TCK loopback of tdi, or tdo tied high
  bit   tdo_tied = 1'b0;
  logic loop_d = 1'b0;
  always @(posedge tck) begin
    if (tdo_tied) tdo = 1'b1;
    else begin
      tdo = loop_d;
      loop_d = tdi;
    end
  end

  // Passive monitor of the JTAG pins
  int          tck_count = 0;
  int          done_count = 0;
  logic [63:0] tms_log = '0;
  logic [63:0] tdi_log = '0;
  bit   [15:0] visited = '0;
  logic        tck_prev = 1'b0;
  always @(negedge clk) begin
    if (tck && !tck_prev) begin
      if (tck_count < 64) begin
        tms_log[tck_count] = tms;
        tdi_log[tck_count] = tdi;
      end
      tck_count++;
    end
    tck_prev = tck;
    visited[tapState] = 1'b1;
    if (bus.done) done_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] build_tms(input int n, input int m);
    logic [63:0] s;
    int p;
    s = '0;
    p = 0;
    for (int i = 0; i < PRE; i++) begin
      s[p] = (i < 5);
      p++;
    end
    s[p] = 1'b1; s[p+1] = 1'b1; p += 4;
    p += n - 1;  s[p] = 1'b1; p += 1;
    s[p] = 1'b1; p += 2;
    s[p] = 1'b1; p += 3;
    p += m - 1;  s[p] = 1'b1; p += 1;
    s[p] = 1'b1;
    return s;
  endfunction

  task automatic wait_ready(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.startReady;
    end
    if (!seen) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drive_req(input logic [4:0] op, input int n, input logic [31:0] vec, input int m,
                           input bit tied);
    tdo_tied = tied;
    loop_d = 1'b0;
    tck_count = 0;
    tms_log = '0;
    tdi_log = '0;
    visited = '0;
    bus.startValid  = 1'b1;
    bus.testVector  = vec;
    bus.vectorWidth = 6'(m);
    bus.instrWidth  = 3'(n);
    bus.instrOpcode = op;
    @(posedge clk);
    #1;
    bus.startValid  = 1'b0;
    bus.testVector  = $urandom;
    bus.vectorWidth = 6'($urandom);
    bus.instrWidth  = 3'($urandom);
    bus.instrOpcode = 5'($urandom);
  endtask

  task automatic run_scan(input logic [4:0] op, input int n, input logic [31:0] vec, input int m,
                          input bit tied, input string tag);
    exp_t e;
    int   cyc;
    int   done0;
    bit   seen;
    bit   legal;
    legal    = (m == 8 || m == 16 || m == 24 || m == 32) && n >= 3 && n <= 5;
    e.is_err = !legal;
    e.tcks   = legal ? n + m + 11 + PRE : 0;
    if (!legal)    e.cap = '0;
    else if (tied) e.cap = 32'(mask(m));
    else           e.cap = 32'(({32'd0, vec} << 1) & mask(m));
    e.tms_seq = legal ? build_tms(n, m) : 64'd0;

    wait_ready(tag);
    sb_q.push_back(e);
    drive_req(op, n, vec, m, tied);
    done0 = done_count;
    check({tag, "_ready_low"}, 64'(bus.startReady), 64'd0);

    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.done || bus.error) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, "_resp_timeout"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_error"}, 64'(bus.error), 64'(e.is_err));
    check({tag, "_done"}, 64'(bus.done), 64'(!e.is_err));
    check({tag, "_latency"}, 64'(cyc), e.is_err ? 64'd2 : 64'(2 * e.tcks + 1));
    check({tag, "_cap"}, 64'(bus.capturedData), 64'(e.cap));
    check({tag, "_tcks"}, 64'(tck_count), 64'(e.tcks));
    check({tag, "_ready_at_resp"}, 64'(bus.startReady), e.is_err ? 64'd0 : 64'd1);
    if (!e.is_err) begin
      check({tag, "_tms_seq"}, tms_log, e.tms_seq);
      check({tag, "_ir_tdi"}, (tdi_log >> (PRE + 4)) & mask(n), 64'(op) & mask(n));
      check({tag, "_dr_tdi"}, (tdi_log >> (PRE + n + 9)) & mask(m), 64'(vec) & mask(m));
      check({tag, "_visit_exit1ir_shiftdr"}, 64'({visited[6], visited[11]}), 64'd3);
`ifdef JTAG_RESET_ON_START_EN
      check({tag, "_visit_reset"}, 64'(visited[0]), 64'd1);
`endif
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, 64'({bus.done, bus.error}), 64'd0);
    check({tag, "_ready_after"}, 64'(bus.startReady), 64'd1);
    check({tag, "_cap_hold"}, 64'(bus.capturedData), 64'(e.cap));
    check({tag, "_done_count"}, 64'(done_count - done0), legal ? 64'd1 : 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done0;
    bit seen;
    bus.startValid  = 1'b0;
    bus.testVector  = '0;
    bus.vectorWidth = '0;
    bus.instrWidth  = '0;
    bus.instrOpcode = '0;

    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_ready", 64'(bus.startReady), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    check("rst_cap", 64'(bus.capturedData), 64'd0);
    check("rst_tap", 64'(tapState), 64'd0);

    reset = 1'b1;
    @(negedge clk);
    check("boot1_tms", 64'({tck, tms, bus.startReady}), 64'd0);
    check("boot1_tap", 64'(tapState), 64'd0);
    @(negedge clk);
    check("boot2_tck", 64'(tck), 64'd1);
    check("boot2_tap", 64'(tapState), 64'd1);
    check("boot2_ready", 64'(bus.startReady), 64'd0);
    @(negedge clk);
    check("boot3_tck", 64'(tck), 64'd0);
    check("boot3_ready", 64'(bus.startReady), 64'd1);

    run_scan(5'b00010, 5, 32'h000000A5, 8, 1'b0, "ir5_dr8_loop");
    run_scan(5'b00000, 3, 32'hDEADBEEF, 32, 1'b1, "ir3_dr32_ones");
    run_scan(5'b00001, 4, 32'h0000C3A7, 16, 1'b0, "ir4_dr16_loop");
    run_scan(5'b10110, 5, 32'h5A5A5A5A, 24, 1'b1, "ir5_dr24_ones");
    run_scan(5'b00010, 3, 32'h12345678, 12, 1'b0, "bad_vw12");
    run_scan(5'b00010, 6, 32'h12345678, 8, 1'b0, "bad_iw6");
    run_scan(5'b00010, 2, 32'h12345678, 16, 1'b0, "bad_iw2");
    run_scan(5'b11111, 5, 32'hFFFFFFFF, 32, 1'b0, "ir5_dr32_loop");
    for (int i = 0; i < 3; i++) begin
      run_scan(5'($urandom), int'($urandom_range(3, 5)), $urandom,
               8 * int'($urandom_range(1, 4)), 1'b0, "rand_loop");
    end

    // Reset asserted in the middle of a DR shift
    wait_ready("midrst");
    drive_req(5'b00001, 4, 32'h0000BEEF, 16, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = (tapState == 4'd11);
    end
    check("midrst_reach_shiftdr", 64'(tapState), 64'd11);
    done0 = done_count;
    reset = 1'b0;
    #1;
    check("midrst_tck", 64'(tck), 64'd0);
    check("midrst_tms", 64'(tms), 64'd1);
    check("midrst_tap", 64'(tapState), 64'd0);
    check("midrst_ready", 64'(bus.startReady), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ready("midrst_recover");
    check("midrst_idle_tap", 64'(tapState), 64'd1);
    repeat (80) @(negedge clk);
    check("midrst_no_done", 64'(done_count - done0), 64'd0);

    run_scan(5'b00010, 5, 32'h000000A5, 8, 1'b0, "post_rst_scan");
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
